sort_stream_host: RTL and testbench
===================================

Name: sort_stream_host

Overview:
- Host-side initiator for the 8-entry in-place sorter's external memory/start interface.
- Accepts a stream of N input words and writes them into the sorter's RAM, then pulses start and waits for the sorter to finish.
- Reads the sorted words back and emits them in ascending address order on an output stream with backpressure.
- Sits between a valid/ready producer/consumer pair and the sorter instance.

Parameters:
- N, 8, number of elements per batch; must equal sorter depth.
- W, 8, data word width.
- AW, $clog2(N) = 3, sorter address width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  W  input word.
- in_valid  in  1  input word present.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  W  sorted output word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data.
- busy  out  1  high in every state except LOAD.
- done  out  1  one-cycle pulse on the handshake of the last output word.
- s_addr  out  AW  sorter address (write and read).
- s_datain  out  W  sorter write data.
- s_wr  out  1  sorter write enable.
- s_start  out  1  sorter start.
- s_dataout  in  W  sorter read data; registered, 1-cycle latency from s_addr.
- s_ready  in  1  sorter idle; owns external port.

Behaviour:
- Reset (async, rst=1):
  - state=LOAD, idx=0.
  - in_ready, out_valid, s_wr, s_start, done, busy all 0.
  - s_addr=0, s_datain=0.
  - The sorter's active-low reset is driven as !rst by the integrating top.
- States: LOAD, START, WAIT, FETCH, PRESENT. Counter idx is AW bits.
- LOAD:
  - in_ready = s_ready.
  - s_addr=idx, s_datain=in_data, s_wr = in_valid && in_ready (combinational).
  - On each accepted word: if idx==N-1 then idx<=0 and go to START; else idx<=idx+1.
  - Gaps in in_valid stall with no writes.
- START:
  - s_start = s_ready.
  - If s_ready: go to WAIT. Otherwise hold in START.
  - s_start is high for exactly one cycle.
- WAIT:
  - s_wr=0, s_start=0, s_addr=0.
  - Stay in WAIT while !s_ready. When s_ready==1, go to FETCH with idx=0.
  - s_ready is already low in the first WAIT cycle, because the sorter leaves idle on the start edge.
- FETCH:
  - s_addr=idx, one cycle, then go to PRESENT.
- PRESENT:
  - s_addr=idx is held, out_valid=1, out_data=s_dataout.
  - out_data is stable while stalled: the address is unchanged and no writes occur.
  - On out_valid && out_ready: if idx==N-1 then done=1, idx<=0, go to LOAD; else idx<=idx+1, go to FETCH.
- Throughput: 1 word per 2 cycles on output; 1 word per cycle on input.
- Boundaries:
  - idx wraps only via an explicit clear at N-1; it never wraps through overflow.
  - in_ready=0 in every state except LOAD.
  - out_valid=0 in every state except PRESENT.
  - A new batch may begin in the cycle after done.
- Reset mid-operation: immediate return to LOAD/idx=0. A partially loaded or partially read batch is discarded.
- Unsigned compare semantics are the sorter's concern; this block never inspects data values.

Decomposition:
- Package sort_pkg holds:
  - state enum host_state_t {LOAD, START, WAIT, FETCH, PRESENT};
  - localparams N_ELEM=8, WORD_W=8, ADDR_W=3, shared with the sorter.
- No sub-module is needed: one FSM plus one index counter.
- Integration top sort_stream instantiates sort_stream_host and the sorter; it is not part of this block.

Test Plan:
- Reset with rst held 3 cycles, then released -> in_ready=1 (s_ready=1), out_valid=0, s_start=0, busy=0, done=0.
- Stream 5,3,7,1,0,6,2,4 with continuous in_valid -> s_wr on addr 0..7 in consecutive cycles; s_start high exactly one cycle after the 8th write; in_ready=0 from then on.
- Full batch against the real sorter with out_ready=1 -> outputs 0,1,2,3,4,5,6,7 in order, 2 cycles apart; done pulses with word 7; busy then falls.
- Batch 9,9,1,255,0,9,1,128 with out_ready low for 5 cycles on word 2 -> outputs 0,1,1,9,9,9,128,255; word 2 holds value 1 and out_valid=1 throughout the stall.
- Input gaps (in_valid 1,0,0,1,...) -> writes occur only on accepted cycles, addresses remain contiguous 0..7; a rst pulse during WAIT -> state LOAD, idx 0, no s_start, next batch sorts correctly.
- Two back-to-back batches, the second's in_valid asserted in the done cycle -> first word of batch 2 accepted in the cycle after done; both batches are output sorted.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared types and sizes for the 8-entry sorter and its stream host.
package sort_pkg;
  localparam int N_ELEM = 8;
  localparam int WORD_W = 8;
  localparam int ADDR_W = 3;

  typedef enum logic [2:0] {
    LOAD    = 3'd0,
    START   = 3'd1,
    WAIT    = 3'd2,
    FETCH   = 3'd3,
    PRESENT = 3'd4
  } host_state_t;
endpackage

// File: rtl/sort_stream_host.sv
// Streams a batch into the sorter RAM, kicks a sort, then reads the sorted
// words back out on a valid/ready stream, one word every two cycles.
module sort_stream_host
  import sort_pkg::*;
#(
  parameter int N  = N_ELEM,
  parameter int W  = WORD_W,
  parameter int AW = ADDR_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] s_addr,
  output logic [W-1:0]  s_datain,
  output logic          s_wr,
  output logic          s_start,
  input  logic [W-1:0]  s_dataout,
  input  logic          s_ready
);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  host_state_t   state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Outputs are forced quiet while rst is held so nothing leaks to the sorter.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    s_addr    = '0;
    s_datain  = '0;
    s_wr      = 1'b0;
    s_start   = 1'b0;
    done      = 1'b0;
    busy      = 1'b0;
    if (!rst) begin
      busy = (state_q != LOAD);
      case (state_q)
        LOAD: begin
          in_ready = s_ready;
          s_addr   = idx_q;
          s_datain = in_data;
          s_wr     = in_valid && s_ready;
          if (s_wr) begin
            if (idx_q == LAST) begin
              idx_d   = '0;
              state_d = START;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        START: begin
          s_start = s_ready;
          if (s_ready) state_d = WAIT;
        end
        WAIT: begin
          // The sorter drops s_ready on the start edge, so high here means finished.
          if (s_ready) begin
            idx_d   = '0;
            state_d = FETCH;
          end
        end
        FETCH: begin
          s_addr  = idx_q;
          state_d = PRESENT;
        end
        PRESENT: begin
          s_addr    = idx_q;
          out_valid = 1'b1;
          out_data  = s_dataout;
          if (out_ready) begin
            if (idx_q == LAST) begin
              done    = 1'b1;
              idx_d   = '0;
              state_d = LOAD;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = FETCH;
            end
          end
        end
        default: state_d = LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_sort_stream_host.sv
// Bench for sort_stream_host with a behavioural sorter and a queue scoreboard.
module tb_sort_stream_host;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy, done;
  logic [2:0] s_addr;
  logic [7:0] s_datain;
  logic       s_wr, s_start;
  logic [7:0] s_dataout;
  logic       s_ready;

  sort_stream_host dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .done(done), .s_addr(s_addr), .s_datain(s_datain), .s_wr(s_wr), .s_start(s_start),
    .s_dataout(s_dataout), .s_ready(s_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural sorter: registered read, writes only while idle, busy for a
  // few cycles after start, then the RAM holds the ascending permutation.
  logic [7:0][7:0] smem;
  int              scnt;

  function automatic logic [7:0][7:0] sorted8(input logic [7:0][7:0] a);
    logic [7:0][7:0] t;
    logic [7:0]      x;
    t = a;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 7 - i; j++)
        if (t[j] > t[j+1]) begin
          x = t[j]; t[j] = t[j+1]; t[j+1] = x;
        end
    return t;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ready   <= 1'b1;
      scnt      <= 0;
      s_dataout <= '0;
    end else begin
      s_dataout <= smem[s_addr];
      if (s_ready && s_wr) smem[s_addr] <= s_datain;
      if (s_ready && s_start) begin
        s_ready <= 1'b0;
        scnt    <= 6;
      end else if (!s_ready) begin
        if (scnt == 0) begin
          smem    <= sorted8(smem);
          s_ready <= 1'b1;
        end else begin
          scnt <= scnt - 1;
        end
      end
    end
  end

  // Scoreboard and monitors
  logic [7:0] exp_q[$];
  int  mon_word = 0;
  int  batches_done = 0;
  int  last_hs = 0;
  int  done_cyc = -10;
  bit  batch_stalled = 0;
  bit  stall_seen = 0;
  logic [7:0] held;
  bit  prev_done = 0;
  int  stall_at = -1;
  int  stall_left = 0;
  int  wr_idx = 0;
  bit  prev_wr = 0;
  bit  prev_start = 0;
  bit  start_seen = 0;
  bit  b2b_check = 0;

  initial out_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    if (stall_left > 0 && out_valid && mon_word == stall_at) begin
      out_ready  = 1'b0;
      stall_left = stall_left - 1;
    end else begin
      out_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      mon_word = 0; batch_stalled = 0; stall_seen = 0; prev_done = 0;
    end else begin
      if (prev_done) check("busy_after_done", busy, 1'b0);
      prev_done = done;
      if (done && !(out_valid && out_ready)) check("done_without_hs", done, 1'b0);
      if (!out_valid) check("in_ready_when_idle_state", in_ready, (busy ? 1'b0 : s_ready));
      if (out_valid && !out_ready) begin
        batch_stalled = 1;
        if (stall_seen) check("stall_data_stable", out_data, held);
        else begin held = out_data; stall_seen = 1; end
        check("in_ready_during_present", in_ready, 1'b0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_output", 1, 0);
        else check($sformatf("out_word%0d", mon_word), out_data, exp_q.pop_front());
        check("done_on_last", done, (mon_word == 7));
        if (mon_word > 0 && !batch_stalled) check("out_spacing", cyc - last_hs, 2);
        last_hs = cyc;
        stall_seen = 0;
        if (mon_word == 7) begin
          mon_word = 0; batch_stalled = 0; batches_done++; done_cyc = cyc;
        end else mon_word++;
      end
    end
  end

  // Write/start monitor: addresses contiguous, start exactly after 8th write.
  always @(negedge clk) begin
    if (rst) begin
      wr_idx = 0; prev_wr = 0; prev_start = 0;
      check("no_start_in_reset", s_start, 1'b0);
    end else begin
      if (s_start) begin
        check("start_after_8th_write", {prev_wr, wr_idx[2:0]}, 4'b1000);
        check("start_one_cycle", prev_start, 1'b0);
        start_seen = 1;
      end
      if (s_wr) begin
        check("wr_addr", s_addr, wr_idx[2:0]);
        if (b2b_check && wr_idx == 0) begin
          check("b2b_first_accept", cyc - done_cyc, 1);
          b2b_check = 0;
        end
        wr_idx = (wr_idx + 1) % 8;
      end
      prev_wr = s_wr;
      prev_start = s_start;
    end
  end

  task automatic push(input logic [7:0] v, input int gap);
    int n;
    in_data = v; in_valid = 1'b1; n = 0;
    while (!in_ready && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 300) check("in_ready_timeout", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0][7:0] v, input logic [7:0][7:0] e, input int gap, input bit expect_out);
    for (int i = 0; i < 8; i++) begin
      if (expect_out) exp_q.push_back(e[i]);
    end
    for (int i = 0; i < 8; i++) push(v[i], gap);
  endtask

  task automatic wait_batches(input int n);
    int t = 0;
    while (batches_done < n && t < 500) begin @(posedge clk); #1; t++; end
    check("batch_complete", batches_done, n);
  endtask

  // Packed vector element [i] is the i-th word in stream order.
  function automatic logic [7:0][7:0] vec(input int a0, a1, a2, a3, a4, a5, a6, a7);
    logic [7:0][7:0] r;
    r[0] = 8'(a0); r[1] = 8'(a1); r[2] = 8'(a2); r[3] = 8'(a3);
    r[4] = 8'(a4); r[5] = 8'(a5); r[6] = 8'(a6); r[7] = 8'(a7);
    return r;
  endfunction

  initial begin
    int t;
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_s_wr", s_wr, 1'b0);
    check("rst_s_addr", s_addr, 3'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1'b1);
    check("post_rst_out_valid", out_valid, 1'b0);
    check("post_rst_s_start", s_start, 1'b0);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_done", done, 1'b0);
    @(posedge clk); #1;

    send(vec(5,3,7,1,0,6,2,4), vec(0,1,2,3,4,5,6,7), 0, 1);
    wait_batches(1);

    stall_at = 2; stall_left = 5;
    send(vec(9,9,1,255,0,9,1,128), vec(0,1,1,9,9,9,128,255), 0, 1);
    wait_batches(2);

    // Gapped batch, then reset while the sorter is working: batch discarded.
    start_seen = 0;
    send(vec(20,10,30,60,50,40,80,70), vec(0,0,0,0,0,0,0,0), 2, 0);
    t = 0;
    while (!start_seen && t < 50) begin @(posedge clk); #1; t++; end
    check("gapped_start_seen", start_seen, 1'b1);
    @(posedge clk); #1;
    check("in_wait_sorter_busy", s_ready, 1'b0);
    check("in_wait_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", busy, 1'b0);
    check("midrst_in_ready", in_ready, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("after_midrst_in_ready", in_ready, 1'b1);
    check("after_midrst_busy", busy, 1'b0);
    @(posedge clk); #1;
    send(vec(50,40,30,20,10,0,70,60), vec(0,10,20,30,40,50,60,70), 0, 1);
    wait_batches(3);

    // Back-to-back: second batch's first word waits with in_valid high through done.
    send(vec(200,100,150,50,250,0,25,75), vec(0,25,50,75,100,150,200,250), 0, 1);
    b2b_check = 1;
    send(vec(7,6,5,4,3,2,1,0), vec(0,1,2,3,4,5,6,7), 0, 1);
    wait_batches(5);
    check("b2b_checked", b2b_check, 1'b0);
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
